// File: rtl/tcm_port_arbiter.sv
// Single-port ITCM arbiter: auto-load, data IF and instruction IF share one SRAM macro.
// Fixed priority (load > starved instr > data > instr) with one-cycle read return.
module tcm_port_arbiter #(
    parameter int unsigned            ADDR_WIDTH     = 32,
    parameter int unsigned            DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0]  TCM_START_ADDR = '0,
    parameter int unsigned            WORD_AW        = 13,
    parameter int unsigned            STARVE_LIMIT   = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load_active,
    input  logic                  load_wr,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_wdata,
    input  logic                  data_access,
    input  logic                  data_rd0_wr1,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [3:0]            data_byte_strobe,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    output logic                  data_ready,
    output logic [DATA_WIDTH-1:0] data_read_data,
    output logic                  data_read_data_valid,
    input  logic                  instr_access,
    input  logic [ADDR_WIDTH-1:0] instr_addr,
    output logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_read_data,
    output logic                  instr_read_data_valid,
    output logic [WORD_AW-1:0]    sram_addr,
    output logic                  sram_wen,
    output logic                  sram_ren,
    output logic [3:0]            sram_ben,
    output logic [DATA_WIDTH-1:0] sram_wd,
    input  logic [DATA_WIDTH-1:0] sram_rd
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic {BOOT, RUN} state_t;

    state_t                state, state_next;
    logic [3:0]            starve_cnt, starve_next;
    logic [WORD_AW-1:0]    addr_shadow;
    logic                  grant_load, grant_data, grant_instr, any_grant;
    logic                  override, core_ok;
    logic [ADDR_WIDTH-1:0] grant_addr, offset;
    logic                  unused_offset;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state                 <= BOOT;
            starve_cnt            <= '0;
            addr_shadow           <= '0;
            data_read_data_valid  <= 1'b0;
            instr_read_data_valid <= 1'b0;
        end else begin
            state                 <= state_next;
            starve_cnt            <= starve_next;
            if (any_grant)
                addr_shadow <= offset[WORD_AW+1:2];
            data_read_data_valid  <= grant_data && !data_rd0_wr1;
            instr_read_data_valid <= grant_instr;
        end
    end

    // Core ports are also blocked in the very cycle load_active rises, before BOOT is entered.
    always_comb begin
        state_next  = state;
        core_ok     = (state == RUN) && !load_active;
        override    = instr_access && (starve_cnt == LIMIT);
        grant_load  = load_wr;
        grant_instr = core_ok && !load_wr && instr_access && (override || !data_access);
        grant_data  = core_ok && !load_wr && data_access && !override;
        any_grant   = grant_load || grant_data || grant_instr;

        case (state)
            BOOT:    if (!load_active) state_next = RUN;
            RUN:     if (load_active)  state_next = BOOT;
            default: state_next = BOOT;
        endcase

        starve_next = '0;
        if (state == RUN && instr_access && !grant_instr)
            starve_next = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 4'd1;
    end

    always_comb begin
        sram_wen   = 1'b0;
        sram_ren   = 1'b0;
        sram_ben   = '0;
        sram_wd    = '0;
        grant_addr = instr_addr;
        if (grant_load) begin
            sram_wen   = 1'b1;
            sram_ben   = '1;
            sram_wd    = load_wdata;
            grant_addr = load_addr;
        end else if (grant_data) begin
            grant_addr = data_addr;
            if (data_rd0_wr1) begin
                sram_wen = 1'b1;
                sram_ben = data_byte_strobe;
                sram_wd  = data_wdata;
            end else begin
                sram_ren = 1'b1;
            end
        end else if (grant_instr) begin
            sram_ren = 1'b1;
        end
    end

    assign offset          = grant_addr - TCM_START_ADDR;
    assign unused_offset   = ^offset;
    assign sram_addr       = any_grant ? offset[WORD_AW+1:2] : addr_shadow;
    assign data_ready      = grant_data;
    assign instr_ready     = grant_instr;
    assign data_read_data  = sram_rd;
    assign instr_read_data = sram_rd;

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Directed vector stream for tcm_port_arbiter plus a hand-written mid-access reset sequence.
module tb_tcm_port_arbiter;

    localparam logic [31:0] B = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        load_active, load_wr, data_access, data_rd0_wr1, instr_access;
    logic [31:0] load_addr, load_wdata, data_addr, data_wdata, instr_addr, sram_rd;
    logic [3:0]  data_byte_strobe;
    logic        data_ready, data_read_data_valid, instr_ready, instr_read_data_valid;
    logic [31:0] data_read_data, instr_read_data, sram_wd;
    logic [12:0] sram_addr;
    logic        sram_wen, sram_ren;
    logic [3:0]  sram_ben;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tcm_port_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TCM_START_ADDR(B), .WORD_AW(13), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rstn(rstn),
        .load_active(load_active), .load_wr(load_wr), .load_addr(load_addr), .load_wdata(load_wdata),
        .data_access(data_access), .data_rd0_wr1(data_rd0_wr1), .data_addr(data_addr),
        .data_byte_strobe(data_byte_strobe), .data_wdata(data_wdata), .data_ready(data_ready),
        .data_read_data(data_read_data), .data_read_data_valid(data_read_data_valid),
        .instr_access(instr_access), .instr_addr(instr_addr), .instr_ready(instr_ready),
        .instr_read_data(instr_read_data), .instr_read_data_valid(instr_read_data_valid),
        .sram_addr(sram_addr), .sram_wen(sram_wen), .sram_ren(sram_ren), .sram_ben(sram_ben),
        .sram_wd(sram_wd), .sram_rd(sram_rd)
    );

    typedef struct {
        bit la, lw; logic [31:0] laddr;
        bit da, dw; logic [31:0] daddr; logic [3:0] strb;
        bit ia; logic [31:0] iaddr;
        bit dr, ir, wen, ren; logic [3:0] ben; logic [12:0] addr; bit dv, iv;
    } vec_t;

    vec_t tbl[27];

    function automatic vec_t mk(bit la, bit lw, logic [31:0] laddr, bit da, bit dw, logic [31:0] daddr,
                                logic [3:0] strb, bit ia, logic [31:0] iaddr, bit dr, bit ir, bit wen,
                                bit ren, logic [3:0] ben, logic [12:0] addr, bit dv, bit iv);
        vec_t v;
        v.la = la; v.lw = lw; v.laddr = laddr; v.da = da; v.dw = dw; v.daddr = daddr; v.strb = strb;
        v.ia = ia; v.iaddr = iaddr; v.dr = dr; v.ir = ir; v.wen = wen; v.ren = ren; v.ben = ben;
        v.addr = addr; v.dv = dv; v.iv = iv;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic idle_inputs();
        load_active = 0; load_wr = 0; load_addr = '0; load_wdata = '0;
        data_access = 0; data_rd0_wr1 = 0; data_addr = '0; data_byte_strobe = '0; data_wdata = '0;
        instr_access = 0; instr_addr = '0; sram_rd = '0;
    endtask

    initial begin
        // la lw laddr  da dw daddr  strb ia iaddr | dr ir wen ren ben addr dv iv
        tbl[0]  = mk(1,1,B+0,    1,0,B+'h20,0, 1,B+'h40, 0,0,1,0,4'hf,0, 0,0);
        tbl[1]  = mk(1,1,B+4,    1,0,B+'h20,0, 1,B+'h40, 0,0,1,0,4'hf,1, 0,0);
        tbl[2]  = mk(1,1,B+8,    1,0,B+'h20,0, 1,B+'h40, 0,0,1,0,4'hf,2, 0,0);
        tbl[3]  = mk(1,1,B+'hC,  1,0,B+'h20,0, 1,B+'h40, 0,0,1,0,4'hf,3, 0,0);
        tbl[4]  = mk(0,0,0,      1,0,B+'h20,0, 1,B+'h40, 0,0,0,0,4'h0,3, 0,0);
        tbl[5]  = mk(0,0,0,      1,0,B+'h10,0, 1,B+'h40, 1,0,0,1,4'h0,4, 0,0);
        tbl[6]  = mk(0,0,0,      0,0,0,     0, 1,B+'h40, 0,1,0,1,4'h0,16,1,0);
        tbl[7]  = mk(0,0,0,      0,0,0,     0, 0,0,      0,0,0,0,4'h0,16,0,1);
        tbl[8]  = mk(0,0,0,      1,0,B+'h20,0, 1,B+'h44, 1,0,0,1,4'h0,8, 0,0);
        tbl[9]  = mk(0,0,0,      1,0,B+'h20,0, 1,B+'h44, 1,0,0,1,4'h0,8, 1,0);
        tbl[10] = tbl[9];
        tbl[11] = tbl[9];
        tbl[12] = mk(0,0,0,      1,0,B+'h20,0, 1,B+'h44, 0,1,0,1,4'h0,17,1,0);
        tbl[13] = mk(0,0,0,      1,0,B+'h20,0, 1,B+'h44, 1,0,0,1,4'h0,8, 0,1);
        tbl[14] = tbl[9];
        tbl[15] = tbl[9];
        tbl[16] = tbl[9];
        tbl[17] = tbl[12];
        tbl[18] = mk(0,0,0,      1,1,B+8,   3, 0,0,      1,0,1,0,4'h3,2, 0,1);
        tbl[19] = mk(0,0,0,      0,0,0,     0, 0,0,      0,0,0,0,4'h0,2, 0,0);
        tbl[20] = mk(0,0,0,      0,0,0,     0, 1,B+'h48, 0,1,0,1,4'h0,18,0,0);
        tbl[21] = mk(1,0,0,      1,0,B+'h20,0, 1,B+'h44, 0,0,0,0,4'h0,18,0,1);
        tbl[22] = mk(1,0,0,      1,0,B+'h20,0, 1,B+'h44, 0,0,0,0,4'h0,18,0,0);
        tbl[23] = mk(0,0,0,      1,0,B+'h20,0, 1,B+'h44, 0,0,0,0,4'h0,18,0,0);
        tbl[24] = mk(0,0,0,      1,0,B+'h20,0, 1,B+'h44, 1,0,0,1,4'h0,8, 0,0);
        // Out-of-macro address wraps; low byte bits are ignored.
        tbl[25] = mk(0,1,B+'h8031,1,0,B+'h20,0,1,B+'h44, 0,0,1,0,4'hf,12,1,0);
        tbl[26] = mk(0,0,0,      0,0,0,     0, 0,0,      0,0,0,0,4'h0,12,0,0);

        idle_inputs();
        rstn = 0;
        repeat (2) @(negedge clk);
        #4;
        check("reset_dvalid", -1, 32'(data_read_data_valid), 0);
        check("reset_ivalid", -1, 32'(instr_read_data_valid), 0);
        check("reset_addr",   -1, 32'(sram_addr), 0);
        check("reset_wen",    -1, 32'(sram_wen), 0);
        check("reset_ren",    -1, 32'(sram_ren), 0);
        @(negedge clk);
        rstn = 1;

        for (int i = 0; i < 27; i++) begin
            if (i > 0) @(negedge clk);
            load_active = tbl[i].la; load_wr = tbl[i].lw; load_addr = tbl[i].laddr;
            load_wdata = 32'h1111_0000 + 32'(i);
            data_access = tbl[i].da; data_rd0_wr1 = tbl[i].dw; data_addr = tbl[i].daddr;
            data_byte_strobe = tbl[i].strb; data_wdata = 32'h2222_0000 + 32'(i);
            instr_access = tbl[i].ia; instr_addr = tbl[i].iaddr;
            sram_rd = 32'hC0DE_0000 + 32'(i);
            #4;
            check("data_ready",  i, 32'(data_ready),  32'(tbl[i].dr));
            check("instr_ready", i, 32'(instr_ready), 32'(tbl[i].ir));
            check("sram_wen",    i, 32'(sram_wen),    32'(tbl[i].wen));
            check("sram_ren",    i, 32'(sram_ren),    32'(tbl[i].ren));
            check("sram_ben",    i, 32'(sram_ben),    32'(tbl[i].ben));
            check("sram_addr",   i, 32'(sram_addr),   32'(tbl[i].addr));
            check("dvalid",      i, 32'(data_read_data_valid),  32'(tbl[i].dv));
            check("ivalid",      i, 32'(instr_read_data_valid), 32'(tbl[i].iv));
            if (tbl[i].wen)
                check("sram_wd", i, sram_wd, tbl[i].lw ? 32'h1111_0000 + 32'(i) : 32'h2222_0000 + 32'(i));
            if (tbl[i].dv) check("data_rdata",  i, data_read_data,  32'hC0DE_0000 + 32'(i));
            if (tbl[i].iv) check("instr_rdata", i, instr_read_data, 32'hC0DE_0000 + 32'(i));
        end

        // Reset asserted the cycle after a read grant drops the pending valid.
        @(negedge clk);
        idle_inputs();
        data_access = 1; data_addr = B + 32'h20;
        #4;
        check("rst_seq_grant", 100, 32'(data_ready), 1);
        @(posedge clk);
        #2;
        rstn = 0;
        #1;
        check("rst_seq_dvalid", 101, 32'(data_read_data_valid), 0);
        check("rst_seq_ready",  101, 32'(data_ready), 0);
        check("rst_seq_ren",    101, 32'(sram_ren), 0);
        check("rst_seq_addr",   101, 32'(sram_addr), 0);
        @(negedge clk);
        rstn = 1;
        #4;
        check("rst_seq_boot", 102, 32'(data_ready), 0);
        @(negedge clk);
        #4;
        check("rst_seq_run",    103, 32'(data_ready), 1);
        check("rst_seq_noval",  103, 32'(data_read_data_valid), 0);
        @(negedge clk);
        data_access = 0;
        #4;
        check("rst_seq_val",    104, 32'(data_read_data_valid), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tcm_port_arbiter.md
# tcm_port_arbiter

Shares the single-ported ITCM SRAM macro between three requesters: the auto-load write stream, the data IF (read/write) and the instruction IF (read). It sits between the core's fetch/LSU TCM ports and the raw SRAM. It grants at most one access per cycle, using fixed priority with an instruction anti-starvation override. It routes the one-cycle-latency read data back to the winning requester with a per-port valid pulse.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width
- TCM_START_ADDR, 32'h0000_0000, base byte address subtracted before indexing
- WORD_AW, 13, SRAM word-address width (byte address bits [WORD_AW+1:2])
- STARVE_LIMIT, 4, consecutive denied instr cycles before override (1..15)

Ports:
- clk  in  1  clock
- rstn  in  1  reset; one clock; reset is asynchronous and active-low
- load_active  in  1  auto-load sequence in progress
- load_wr  in  1  auto-load write request
- load_addr  in  ADDR_WIDTH  auto-load byte address
- load_wdata  in  DATA_WIDTH  auto-load data (full-word write)
- data_access  in  1  data IF request
- data_rd0_wr1  in  1  1 = write, 0 = read
- data_addr  in  ADDR_WIDTH  data byte address
- data_byte_strobe  in  4  write byte enables
- data_wdata  in  DATA_WIDTH  data write data
- data_ready  out  1  data request granted this cycle
- data_read_data  out  DATA_WIDTH  equals sram_rd
- data_read_data_valid  out  1  registered; data read completed
- instr_access  in  1  instruction fetch request
- instr_addr  in  ADDR_WIDTH  fetch byte address
- instr_ready  out  1  fetch granted this cycle
- instr_read_data  out  DATA_WIDTH  equals sram_rd
- instr_read_data_valid  out  1  registered; fetch completed
- sram_addr  out  WORD_AW  word address
- sram_wen  out  1  write enable
- sram_ren  out  1  read enable
- sram_ben  out  4  byte enables
- sram_wd  out  DATA_WIDTH  write data
- sram_rd  in  DATA_WIDTH  read data, valid the cycle after sram_ren

## Operation
- FSM states: BOOT and RUN. Reset enters BOOT.
  - BOOT -> RUN on the first cycle with load_active=0.
  - RUN -> BOOT when load_active rises.
- BOOT: only load_wr is serviced. data_ready=0, instr_ready=0, starvation counter held at 0.
- RUN grant order:
  - load_wr first.
  - Then instr, if override is active (instr_access && starve_cnt==STARVE_LIMIT).
  - Then data_access.
  - Then instr_access.
- Exactly one grant or none per cycle. Ready is combinational and reflects the grant this cycle.
- A requester holds its request and its fields stable until ready. A request dropped without ready is legal and is ignored.
- Granted load: sram_wen=1, sram_ben=4'hf, sram_wd=load_wdata.
- Granted data write: sram_wen=1, sram_ben=data_byte_strobe.
- Granted data read or instr read: sram_ren=1, sram_ben=0.
- No grant: sram_wen=0, sram_ren=0, sram_addr holds its last value (registered shadow, not X).
- sram_addr = (granted address - TCM_START_ADDR)[WORD_AW+1:2]. Upper bits are truncated (wrap within the macro). Bits [1:0] are ignored.
- starve_cnt (4 bits):
  - Increments when instr_access=1 and instr is not granted.
  - Saturates at STARVE_LIMIT.
  - Clears on an instr grant or when instr_access=0.
- Rising load_active in RUN:
  - A read granted in the previous cycle still produces its valid pulse.
  - There are no new data or instr grants.

## Timing
- Reset values:
  - data_read_data_valid=0, instr_read_data_valid=0.
  - State BOOT, starve_cnt=0, sram_addr shadow 0.
  - Combinational outputs follow the inputs in BOOT: only load_wr can drive sram_wen.
- Read latency: a read granted in cycle N gives valid=1 in cycle N+1, with data=sram_rd in N+1. Each valid is a single-cycle pulse per grant.
- Back-to-back grants to the same port produce consecutive valid pulses.
- A write produces no valid pulse.
- Reset asserted mid-access: valids clear immediately and the in-flight read is dropped.
- Simultaneous load_wr, data_access and instr_access in RUN: load wins. Both other ready outputs are 0.

## Test plan
- Reset then load_active=1 with 4 load_wr beats to 0x0,0x4,0x8,0xC: sram_wen with ben=f at addr 0..3 each cycle; data_ready=0 throughout even with data_access=1.
- RUN, data read at 0x10 while instr_access=1: cycle 0 data_ready=1 and sram_addr=4; cycle 1 data_read_data_valid=1 and instr_ready=1; cycle 2 instr_read_data_valid=1.
- STARVE_LIMIT=4, data_access and instr_access held high continuously: grants follow the pattern D,D,D,D,I repeated; starve_cnt reaches 4 then clears.
- Data write with strobe 4'b0011 to TCM_START_ADDR+0x8: sram_wen=1, ben=0011, addr=2; no valid pulse follows.
- Instr read granted, load_active rises next cycle: instr_read_data_valid still pulses; later requests get no grant; FSM returns to RUN after load_active=0.
- rstn asserted the cycle after a read grant: no valid pulse; all outputs return to their reset values asynchronously.
